// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// Holds register geometry, the write-source enum and the write bundle.
package regfile_wport_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_WB,
    SRC_MC
  } wsrc_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wreq_t;

endpackage

// File: rtl/wport_fifo.sv
// In-order buffer for multi-cycle unit writes awaiting the write port.
// Ports: push/wr in, pop in, head/full/empty out; sync active-low reset.
module wport_fifo
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  push,
  input  wreq_t wr,
  input  logic  pop,
  output wreq_t head,
  output logic  full,
  output logic  empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wreq_t          mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [PW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full buffer is legal only alongside a pop.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst_n && do_push) begin
      mem[wr_ptr] <= wr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Single register-file write port shared by writeback and multi-cycle units.
// WB has priority; MC writes queue; pending scoreboard drives decode stalls.
module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wb_we,
  input  logic [REG_ADDR_W-1:0] i_wb_addr,
  input  logic [REG_DATA_W-1:0] i_wb_data,
  input  logic                  i_mc_valid,
  input  logic [REG_ADDR_W-1:0] i_mc_addr,
  input  logic [REG_DATA_W-1:0] i_mc_data,
  output logic                  o_mc_ready,
  input  logic                  i_issue_valid,
  input  logic [REG_ADDR_W-1:0] i_issue_addr,
  input  logic [REG_ADDR_W-1:0] i_raddr1,
  input  logic [REG_ADDR_W-1:0] i_raddr2,
  output logic                  o_stall,
  output logic                  o_rf_we,
  output logic [REG_ADDR_W-1:0] o_rf_waddr,
  output logic [REG_DATA_W-1:0] o_rf_wdata,
  output logic                  o_waw_err
);

  wreq_t               head;
  wreq_t               mc_req;
  logic                full;
  logic                empty;
  logic                wb_sel;
  logic                mc_push;
  logic                pop;
  wsrc_e               src;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] set_v;
  logic [NUM_REGS-1:0] clr_v;
  logic [1:0]          age;
  logic                starved;

  assign wb_sel     = i_wb_we && (i_wb_addr != '0);
  assign o_mc_ready = !full;
  assign mc_push    = i_mc_valid && o_mc_ready && (i_mc_addr != '0);
  assign pop        = !wb_sel && !empty;
  assign mc_req     = '{addr: i_mc_addr, data: i_mc_data};

  wport_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (mc_push),
    .wr      (mc_req),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    src = SRC_NONE;
    unique case (1'b1)
      wb_sel: src = SRC_WB;
      pop:    src = SRC_MC;
      default: src = SRC_NONE;
    endcase
  end

  // Set wins over clear on the same bit.
  assign set_v = NUM_REGS'(i_issue_valid && (i_issue_addr != '0))
                 << i_issue_addr;
  assign clr_v = NUM_REGS'(pop) << head.addr;

  assign starved = int'(age) >= STARVE_LIMIT;
  assign o_stall = i_rst_n && (pending[i_raddr1] || pending[i_raddr2]
                               || starved || full);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rf_we    <= 1'b0;
      o_rf_waddr <= '0;
      o_rf_wdata <= '0;
    end else begin
      unique case (src)
        SRC_WB: begin
          o_rf_we    <= 1'b1;
          o_rf_waddr <= i_wb_addr;
          o_rf_wdata <= i_wb_data;
        end
        SRC_MC: begin
          o_rf_we    <= 1'b1;
          o_rf_waddr <= head.addr;
          o_rf_wdata <= head.data;
        end
        default: begin
          o_rf_we    <= 1'b0;
          o_rf_waddr <= '0;
          o_rf_wdata <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pending   <= '0;
      age       <= '0;
      o_waw_err <= 1'b0;
    end else begin
      pending <= (pending & ~clr_v) | set_v;
      if (empty || pop)   age <= '0;
      else if (age != '1) age <= age + 1'b1;
      if (wb_sel && pending[i_wb_addr]) o_waw_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed self-checking bench for regfile_wport_arbiter.
// One task per scenario; each checks its own hand-computed expectations.
module tb_regfile_wport_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_wb_we;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        i_mc_valid;
  logic [4:0]  i_mc_addr;
  logic [31:0] i_mc_data;
  logic        o_mc_ready;
  logic        i_issue_valid;
  logic [4:0]  i_issue_addr;
  logic [4:0]  i_raddr1;
  logic [4:0]  i_raddr2;
  logic        o_stall;
  logic        o_rf_we;
  logic [4:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata;
  logic        o_waw_err;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  regfile_wport_arbiter #(
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (3)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_wb_we       (i_wb_we),
    .i_wb_addr     (i_wb_addr),
    .i_wb_data     (i_wb_data),
    .i_mc_valid    (i_mc_valid),
    .i_mc_addr     (i_mc_addr),
    .i_mc_data     (i_mc_data),
    .o_mc_ready    (o_mc_ready),
    .i_issue_valid (i_issue_valid),
    .i_issue_addr  (i_issue_addr),
    .i_raddr1      (i_raddr1),
    .i_raddr2      (i_raddr2),
    .o_stall       (o_stall),
    .o_rf_we       (o_rf_we),
    .o_rf_waddr    (o_rf_waddr),
    .o_rf_wdata    (o_rf_wdata),
    .o_waw_err     (o_waw_err)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_wb_we       = 1'b0;
    i_wb_addr     = '0;
    i_wb_data     = '0;
    i_mc_valid    = 1'b0;
    i_mc_addr     = '0;
    i_mc_data     = '0;
    i_issue_valid = 1'b0;
    i_issue_addr  = '0;
    i_raddr1      = '0;
    i_raddr2      = '0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    idle_inputs();
    i_wb_we = 1'b1; i_wb_addr = 5'd6; i_wb_data = 32'h1;
    tick();
    tick();
    checks++;
    if (o_rf_we !== 1'b0) begin
      errors++; $display("FAIL rst_we got=%0b exp=0", o_rf_we);
    end
    checks++;
    if (o_rf_waddr !== 5'd0 || o_rf_wdata !== 32'd0) begin
      errors++;
      $display("FAIL rst_wport got=%0d/%h exp=0/0", o_rf_waddr, o_rf_wdata);
    end
    checks++;
    if (o_waw_err !== 1'b0 || o_stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags waw=%0b stall=%0b exp=0/0", o_waw_err, o_stall);
    end
    idle_inputs();
    i_rst_n = 1'b1;
    tick();
    checks++;
    if (o_mc_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready got=%0b exp=1", o_mc_ready);
    end
  endtask

  task automatic test_wb_only();
    i_wb_we = 1'b1; i_wb_addr = 5'd5; i_wb_data = 32'hDEADBEEF;
    tick();
    i_wb_we = 1'b0;
    checks++;
    if (o_rf_we !== 1'b1 || o_rf_waddr !== 5'd5
        || o_rf_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wb_write got=%0b/%0d/%h exp=1/5/deadbeef",
               o_rf_we, o_rf_waddr, o_rf_wdata);
    end
    tick();
    checks++;
    if (o_rf_we !== 1'b0) begin
      errors++; $display("FAIL wb_after got=%0b exp=0", o_rf_we);
    end
  endtask

  task automatic test_mc_idle();
    i_issue_valid = 1'b1; i_issue_addr = 5'd9; i_raddr1 = 5'd9;
    tick();
    i_issue_valid = 1'b0;
    checks++;
    if (o_stall !== 1'b1) begin
      errors++; $display("FAIL mc_pend_stall got=%0b exp=1", o_stall);
    end
    i_mc_valid = 1'b1; i_mc_addr = 5'd9; i_mc_data = 32'h12;
    tick();
    i_mc_valid = 1'b0;
    checks++;
    if (o_rf_we !== 1'b0 || o_stall !== 1'b1) begin
      errors++;
      $display("FAIL mc_nobypass we=%0b stall=%0b exp=0/1", o_rf_we, o_stall);
    end
    tick();
    checks++;
    if (o_rf_we !== 1'b1 || o_rf_waddr !== 5'd9 || o_rf_wdata !== 32'h12) begin
      errors++;
      $display("FAIL mc_write got=%0b/%0d/%h exp=1/9/12",
               o_rf_we, o_rf_waddr, o_rf_wdata);
    end
    checks++;
    if (o_stall !== 1'b0) begin
      errors++; $display("FAIL mc_clr_stall got=%0b exp=0", o_stall);
    end
    i_raddr1 = '0;
    tick();
  endtask

  task automatic test_contention();
    i_wb_we = 1'b1; i_wb_addr = 5'd3; i_wb_data = 32'h33;
    i_mc_valid = 1'b1; i_mc_addr = 5'd7;
    i_mc_data = 32'h70;
    tick();
    checks++;
    if (o_rf_we !== 1'b1 || o_rf_waddr !== 5'd3) begin
      errors++;
      $display("FAIL cont_wbwin got=%0b/%0d exp=1/3", o_rf_we, o_rf_waddr);
    end
    i_mc_data = 32'h71;
    tick();
    checks++;
    if (o_mc_ready !== 1'b0 || o_stall !== 1'b1) begin
      errors++;
      $display("FAIL cont_full ready=%0b stall=%0b exp=0/1", o_mc_ready, o_stall);
    end
    i_mc_data = 32'h72;
    tick();
    i_wb_we = 1'b0; i_mc_valid = 1'b0;
    tick();
    checks++;
    if (o_rf_we !== 1'b1 || o_rf_waddr !== 5'd7 || o_rf_wdata !== 32'h70) begin
      errors++;
      $display("FAIL cont_drain0 got=%0b/%0d/%h exp=1/7/70",
               o_rf_we, o_rf_waddr, o_rf_wdata);
    end
    tick();
    checks++;
    if (o_rf_we !== 1'b1 || o_rf_waddr !== 5'd7 || o_rf_wdata !== 32'h71) begin
      errors++;
      $display("FAIL cont_drain1 got=%0b/%0d/%h exp=1/7/71",
               o_rf_we, o_rf_waddr, o_rf_wdata);
    end
    tick();
    checks++;
    if (o_rf_we !== 1'b0 || o_mc_ready !== 1'b1 || o_stall !== 1'b0) begin
      errors++;
      $display("FAIL cont_empty we=%0b ready=%0b stall=%0b exp=0/1/0",
               o_rf_we, o_mc_ready, o_stall);
    end
  endtask

  task automatic test_starvation();
    i_wb_we = 1'b1; i_wb_addr = 5'd2; i_wb_data = 32'h22;
    i_mc_valid = 1'b1; i_mc_addr = 5'd12; i_mc_data = 32'hC;
    tick();
    i_mc_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (o_stall !== (i == 3)) begin
        errors++;
        $display("FAIL starve_wait%0d got=%0b exp=%0b", i, o_stall, i == 3);
      end
    end
    i_wb_we = 1'b0;
    tick();
    checks++;
    if (o_rf_we !== 1'b1 || o_rf_waddr !== 5'd12 || o_rf_wdata !== 32'hC) begin
      errors++;
      $display("FAIL starve_drain got=%0b/%0d/%h exp=1/12/c",
               o_rf_we, o_rf_waddr, o_rf_wdata);
    end
    checks++;
    if (o_stall !== 1'b0) begin
      errors++; $display("FAIL starve_release got=%0b exp=0", o_stall);
    end
  endtask

  task automatic test_addr0_waw();
    i_mc_valid = 1'b1; i_mc_addr = 5'd0; i_mc_data = 32'h55;
    tick();
    i_mc_valid = 1'b0;
    tick();
    checks++;
    if (o_rf_we !== 1'b0) begin
      errors++; $display("FAIL zero_mc got=%0b exp=0", o_rf_we);
    end
    i_wb_we = 1'b1; i_wb_addr = 5'd0; i_wb_data = 32'h66;
    tick();
    i_wb_we = 1'b0;
    checks++;
    if (o_rf_we !== 1'b0) begin
      errors++; $display("FAIL zero_wb got=%0b exp=0", o_rf_we);
    end
    checks++;
    if (o_waw_err !== 1'b0) begin
      errors++; $display("FAIL waw_clean got=%0b exp=0", o_waw_err);
    end
    i_issue_valid = 1'b1; i_issue_addr = 5'd4;
    tick();
    i_issue_valid = 1'b0;
    i_wb_we = 1'b1; i_wb_addr = 5'd4; i_wb_data = 32'h44;
    tick();
    i_wb_we = 1'b0;
    checks++;
    if (o_waw_err !== 1'b1 || o_rf_waddr !== 5'd4) begin
      errors++;
      $display("FAIL waw_set got=%0b/%0d exp=1/4", o_waw_err, o_rf_waddr);
    end
    tick();
    tick();
    checks++;
    if (o_waw_err !== 1'b1) begin
      errors++; $display("FAIL waw_sticky got=%0b exp=1", o_waw_err);
    end
  endtask

  task automatic test_reset_mid();
    i_wb_we = 1'b1; i_wb_addr = 5'd1; i_wb_data = 32'h11;
    i_issue_valid = 1'b1; i_issue_addr = 5'd20;
    i_mc_valid = 1'b1; i_mc_addr = 5'd20; i_mc_data = 32'hA0;
    tick();
    i_issue_addr = 5'd21;
    i_mc_addr = 5'd21; i_mc_data = 32'hA1;
    tick();
    i_issue_valid = 1'b0; i_mc_valid = 1'b0;
    i_raddr1 = 5'd20; i_raddr2 = 5'd21;
    checks++;
    if (o_mc_ready !== 1'b0 || o_stall !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre ready=%0b stall=%0b exp=0/1", o_mc_ready, o_stall);
    end
    i_wb_we = 1'b0;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_stall !== 1'b0) begin
      errors++; $display("FAIL rmid_in_rst stall=%0b exp=0", o_stall);
    end
    tick();
    i_rst_n = 1'b1;
    #1;
    checks++;
    if (o_rf_we !== 1'b0 || o_mc_ready !== 1'b1 || o_stall !== 1'b0) begin
      errors++;
      $display("FAIL rmid_post we=%0b ready=%0b stall=%0b exp=0/1/0",
               o_rf_we, o_mc_ready, o_stall);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (o_rf_we !== 1'b0 || o_stall !== 1'b0 || o_waw_err !== 1'b0) begin
        errors++;
        $display("FAIL rmid_drop%0d we=%0b stall=%0b waw=%0b exp=0/0/0",
                 i, o_rf_we, o_stall, o_waw_err);
      end
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_wb_only();
    test_mc_idle();
    test_contention();
    test_starvation();
    test_addr0_waw();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
